// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: four-state sequencer driving ALU_wrapper operands, evaluating the ARM
// condition field and strobing the flag latch once per passing S command.
module alu_seq_ctrl #(
   parameter int DATA_W = 32,
   parameter int SNUM_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_cond,
   input  logic [3:0]        cmd_opcode,
   input  logic              cmd_s,
   input  logic [2:0]        cmd_shift_op,
   input  logic [SNUM_W-1:0] cmd_shift_num,
   input  logic [DATA_W-1:0] cmd_rn,
   input  logic [DATA_W-1:0] cmd_rm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_shift_data,
   output logic [SNUM_W-1:0] alu_shift_num,
   output logic [2:0]        alu_shift_op,
   output logic [3:0]        alu_op,
   output logic              alu_s,
   input  logic [DATA_W-1:0] alu_f,
   input  logic [3:0]        nzcv_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_wb,
   output logic              res_skipped
);
   typedef enum logic [1:0] {IDLE, EXEC, FLAG, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0]        cond_q;
   logic              s_q;
   logic              pass_q, pass_d;
   logic              alu_s_q, alu_s_d;
   logic [DATA_W-1:0] rn_q, rm_q, res_q;
   logic [SNUM_W-1:0] snum_q;
   logic [2:0]        sop_q;
   logic [3:0]        op_q;
   logic              n, z, c, v, accept;
   logic [15:0]       cond_tbl;
   assign {n, z, c, v} = nzcv_in;
   // bit k holds the outcome of condition code k (NV at 15 down to EQ at 0)
   assign cond_tbl = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                      ~v, v, ~n, n, ~c, c, ~z, z};
   assign pass_d  = cond_tbl[cond_q];
   assign accept  = cmd_valid && state_q == IDLE;
   assign alu_s_d = state_q == EXEC && pass_d && s_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = cmd_valid ? EXEC : IDLE;
         EXEC:    state_d = FLAG;
         FLAG:    state_d = DONE;
         default: state_d = res_ready ? IDLE : DONE;
      endcase
   end
   always_comb begin
      cmd_ready   = state_q == IDLE;
      res_valid   = state_q == DONE;
      res_wb      = res_valid && pass_q && op_q[3:2] != 2'b10;
      res_skipped = res_valid && !pass_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cond_q  <= '0;
         op_q    <= '0;
         s_q     <= 1'b0;
         sop_q   <= '0;
         snum_q  <= '0;
         rn_q    <= '0;
         rm_q    <= '0;
         res_q   <= '0;
         pass_q  <= 1'b0;
         alu_s_q <= 1'b0;
      end else begin
         if (accept) begin
            cond_q <= cmd_cond;
            op_q   <= cmd_opcode;
            s_q    <= cmd_s;
            sop_q  <= cmd_shift_op;
            snum_q <= cmd_shift_num;
            rn_q   <= cmd_rn;
            rm_q   <= cmd_rm;
         end
         if (state_q == EXEC) begin
            res_q  <= alu_f;
            pass_q <= pass_d;
         end
         alu_s_q <= alu_s_d;
      end
   assign alu_a          = rn_q;
   assign alu_shift_data = rm_q;
   assign alu_shift_num  = snum_q;
   assign alu_shift_op   = sop_q;
   assign alu_op         = op_q;
   assign alu_s          = alu_s_q;
   assign res_data       = res_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and random commands against a behavioural ALU_wrapper
// (shifter, ALU, flag latch on S rising edge) and an ARM condition/result reference.
module tb_alu_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, cmd_valid, cmd_ready, cmd_s, alu_s, res_valid, res_ready, res_wb, res_skipped;
   logic [3:0]  cmd_cond, cmd_opcode, alu_op, nzcv_in;
   logic [2:0]  cmd_shift_op, alu_shift_op;
   logic [7:0]  cmd_shift_num, alu_shift_num;
   logic [31:0] cmd_rn, cmd_rm, alu_a, alu_shift_data, alu_f, res_data;
   logic [3:0]  flags = 4'b0;
   int          s_edges = 0;
   int          n_assert = 0, n_fail = 0;
   logic [35:0] env_r;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.DATA_W(32), .SNUM_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_cond(cmd_cond), .cmd_opcode(cmd_opcode), .cmd_s(cmd_s),
      .cmd_shift_op(cmd_shift_op), .cmd_shift_num(cmd_shift_num),
      .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .alu_a(alu_a), .alu_shift_data(alu_shift_data),
      .alu_shift_num(alu_shift_num), .alu_shift_op(alu_shift_op), .alu_op(alu_op),
      .alu_s(alu_s), .alu_f(alu_f), .nzcv_in(nzcv_in), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_wb(res_wb), .res_skipped(res_skipped));

   function automatic logic [31:0] shf(input logic [2:0] op, input logic [31:0] d, input logic [7:0] amt);
      int k;
      k = int'(amt);
      case (op)
         3'd0:    return k > 31 ? 32'h0 : d << k;
         3'd1:    return k > 31 ? 32'h0 : d >> k;
         3'd2:    return k > 31 ? {32{d[31]}} : 32'($signed(d) >>> k);
         3'd3:    return (d >> (k % 32)) | (d << ((32 - k % 32) % 32));
         default: return d;
      endcase
   endfunction

   function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [31:0] a, b, input logic [3:0] fl);
      logic [31:0] x, y, f;
      logic [32:0] sum;
      logic        ci, arith, c, v;
      arith = 1'b1;
      x = a;
      y = b;
      ci = 1'b0;
      case (op)
         4'd2, 4'd10: begin y = ~b; ci = 1'b1; end
         4'd3:        begin x = b; y = ~a; ci = 1'b1; end
         4'd4, 4'd11: arith = 1'b1;
         4'd5:        ci = fl[1];
         4'd6:        begin y = ~b; ci = fl[1]; end
         4'd7:        begin x = b; y = ~a; ci = fl[1]; end
         default:     arith = 1'b0;
      endcase
      sum = {1'b0, x} + {1'b0, y} + {32'h0, ci};
      case (op)
         4'd0, 4'd8: f = a & b;
         4'd1, 4'd9: f = a ^ b;
         4'd12:      f = a | b;
         4'd13:      f = b;
         4'd14:      f = a & ~b;
         4'd15:      f = ~b;
         default:    f = sum[31:0];
      endcase
      c = arith ? sum[32] : fl[1];
      v = arith ? (x[31] == y[31] && sum[31] != x[31]) : fl[0];
      return {f[31], f == 32'h0, c, v, f};
   endfunction

   function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] fl);
      logic n, z, c, v;
      {n, z, c, v} = fl;
      case (cc)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return z || n != v;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ALU_wrapper stand-in: combinational F, flags latched on every rising edge of S
   always_comb env_r = alu_calc(alu_op, alu_a, shf(alu_shift_op, alu_shift_data, alu_shift_num), flags);
   assign alu_f   = env_r[31:0];
   assign nzcv_in = flags;
   always @(posedge alu_s) begin
      flags   <= env_r[35:32];
      s_edges <= s_edges + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] cc, op, input logic s, input logic [2:0] sop,
                        input logic [7:0] amt, input logic [31:0] rn, rm);
      cmd_cond = cc; cmd_opcode = op; cmd_s = s; cmd_shift_op = sop;
      cmd_shift_num = amt; cmd_rn = rn; cmd_rm = rm; cmd_valid = 1'b1;
   endtask

   task automatic scramble();
      cmd_valid = 1'b0;
      cmd_cond = 4'($urandom); cmd_opcode = 4'($urandom); cmd_s = 1'($urandom);
      cmd_shift_op = 3'($urandom); cmd_shift_num = 8'($urandom);
      cmd_rn = $urandom; cmd_rm = $urandom;
   endtask

   // Called just after a falling edge with the sequencer idle; returns just after a falling edge, idle again.
   task automatic run_cmd(input logic [3:0] cc, op, input logic s, input logic [2:0] sop,
                          input logic [7:0] amt, input logic [31:0] rn, rm, input int hold);
      logic [35:0] r;
      logic        pass, strobe;
      logic [3:0]  f0;
      int          e0;
      f0 = flags;
      e0 = s_edges;
      pass = cond_ok(cc, f0);
      strobe = pass && s;
      r = alu_calc(op, rn, shf(sop, rm, amt), f0);
      drive(cc, op, s, sop, amt, rn, rm);
      chk("ready_idle", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      chk("exec_ready", 32'(cmd_ready), 32'd0);
      chk("exec_valid", 32'(res_valid), 32'd0);
      chk("exec_s", 32'(alu_s), 32'd0);
      chk("exec_a", alu_a, rn);
      chk("exec_sdata", alu_shift_data, rm);
      chk("exec_ctl", {17'h0, alu_op, alu_shift_op, alu_shift_num}, {17'h0, op, sop, amt});
      @(negedge clk);
      chk("flag_s", 32'(alu_s), 32'(strobe));
      chk("flag_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("done_valid", 32'(res_valid), 32'd1);
      chk("done_data", res_data, r[31:0]);
      chk("done_wb", 32'(res_wb), 32'(pass && !(op >= 4'd8 && op <= 4'd11)));
      chk("done_skip", 32'(res_skipped), 32'(!pass));
      chk("done_s", 32'(alu_s), 32'd0);
      chk("done_ready", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_data", res_data, r[31:0]);
         chk("hold_a", alu_a, rn);
         chk("hold_ready_s", {30'h0, cmd_ready, alu_s}, 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("post_ready", 32'(cmd_ready), 32'd1);
      chk("post_valid", 32'(res_valid), 32'd0);
      chk("post_flags", 32'(flags), 32'(strobe ? r[35:32] : f0));
      chk("post_sedges", s_edges, e0 + (strobe ? 1 : 0));
   endtask

   initial begin
      int e0;
      rst_n = 1'b0;
      res_ready = 1'b0;
      scramble();
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_outs", {26'h0, res_valid, res_wb, res_skipped, alu_s, 2'b0}, 32'd0);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_data", res_data, 32'd0);
      chk("rst_ctl", {17'h0, alu_op, alu_shift_op, alu_shift_num}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_cmd(4'hE, 4'd4, 1'b1, 3'd0, 8'd0, 32'd5, 32'd3, 0);
      chk("add_result_flags", 32'(flags), 32'h0);
      run_cmd(4'hE, 4'd13, 1'b1, 3'd0, 8'd0, 32'd9, 32'd0, 0);
      chk("movs_zero_z", 32'(flags), 32'b0100);
      run_cmd(4'h1, 4'd13, 1'b0, 3'd0, 8'd0, 32'd0, 32'h12, 1);
      run_cmd(4'hE, 4'd10, 1'b1, 3'd0, 8'd0, 32'd7, 32'd7, 0);
      chk("cmp_z_set", 32'(flags[2]), 32'd1);
      run_cmd(4'hE, 4'd12, 1'b0, 3'd1, 8'd4, 32'hF0, 32'hAB00, 5);
      run_cmd(4'hF, 4'd4, 1'b1, 3'd0, 8'd0, 32'd1, 32'd1, 0);
      // reset during FLAG: MOVS #0 reproduces the current flags, so the latch shows no change
      e0 = s_edges;
      drive(4'hE, 4'd13, 1'b1, 3'd0, 8'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_s_hi", 32'(alu_s), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_s_lo", 32'(alu_s), 32'd0);
      chk("rstmid_valid", 32'(res_valid), 32'd0);
      chk("rstmid_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rstrel_state", {30'h0, cmd_ready, res_valid}, 32'b10);
         chk("rstrel_flags", 32'(flags), 32'b0110);
         chk("rstrel_sedges", s_edges, e0 + 1);
      end
      for (int i = 0; i < 40; i++)
         run_cmd(4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom_range(0, 4)),
                 8'($urandom_range(0, 40)), $urandom, $urandom, int'($urandom_range(0, 2)));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
